// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Receive side of a multiplexed seven-segment display. The active-low
// anode/cathode bus is registered once, filtered for stability, and each
// stable pattern is consumed exactly once. Valid hex glyphs are decoded back
// into nibbles, and a full 32-bit value is published when all eight digits
// have been seen. Sticky error flags and a scan-loss timeout report a bus
// that does not look like a healthy display scan.

module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        system_clock,
  input  logic        cpu_rst,
  input  logic [7:0]  anode_in,
  input  logic [6:0]  cathodes_in,
  input  logic        err_clear,
  output logic [31:0] value_out,
  output logic        value_valid,
  output logic        value_changed,
  output logic [7:0]  digit_mask,
  output logic        glyph_err,
  output logic        anode_err,
  output logic        scan_lost
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // The acceptance edge is the one on which the counter would reach
  // STABLE_CYCLES-1, i.e. the counter currently holds STABLE_CYCLES-2 and the
  // incoming sample still matches.
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_FILTER = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Glyph decoder: returns {valid, nibble}; segments are {g,f,e,d,c,b,a}, active-low.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0010000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // True when exactly one anode strobe is low.
  function automatic logic one_low(input logic [7:0] an);
    logic [3:0] zeros;
    zeros = 4'd0;
    for (int i = 0; i < 8; i++) begin
      zeros = zeros + {3'b000, ~an[i]};
    end
    return (zeros == 4'd1);
  endfunction

  // Index of the (lowest) low anode strobe.
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!an[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [14:0]      in_s;
  logic             same_s;
  logic [14:0]      samp_r;
  logic [CNT_W-1:0] stab_cnt_r;
  state_t           state_r;
  state_t           state_s;
  logic             accept_s;

  logic [7:0]       anode_s;
  logic [4:0]       glyph_s;
  logic             onehot_s;
  logic [2:0]       idx_s;

  logic [31:0]      frame_r;
  logic [31:0]      frame_s;
  logic [7:0]       mask_r;
  logic [7:0]       mask_s;
  logic [TMO_W-1:0] tmo_r;
  logic [TMO_W-1:0] tmo_s;
  logic             glyph_set_s;
  logic             anode_set_s;
  logic             complete_s;
  logic             lost_rise_s;

  logic [31:0]      value_r;
  logic             valid_r;
  logic             changed_r;
  logic             glyph_err_r;
  logic             anode_err_r;
  logic             scan_lost_r;

  assign in_s   = {anode_in, cathodes_in};
  assign same_s = (in_s == samp_r);

  // Input sample register and stability counter (counts edges the sample repeated).
  always_ff @(posedge system_clock) begin
    if (cpu_rst) begin
      samp_r     <= 15'h7FFF;
      stab_cnt_r <= '0;
    end else begin
      samp_r <= in_s;
      if (!same_s) begin
        stab_cnt_r <= '0;
      end else if (stab_cnt_r != CNT_MAX) begin
        stab_cnt_r <= stab_cnt_r + CNT_W'(1);
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  // Filter FSM state register.
  always_ff @(posedge system_clock) begin
    if (cpu_rst) begin
      state_r <= ST_FILTER;
    end else begin
      state_r <= state_s;
    end
  end

  // Filter FSM next state: a stable pattern is accepted once, then locked out until it changes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_FILTER: begin
        if (same_s && (stab_cnt_r == CNT_ACCEPT)) begin
          state_s  = ST_LOCKED;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_FILTER;
        end
      end
      ST_LOCKED: begin
        if (!same_s) begin
          state_s = ST_FILTER;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_FILTER;
      end
    endcase
  end

  assign anode_s  = samp_r[14:7];
  assign glyph_s  = decode_glyph(samp_r[6:0]);
  assign onehot_s = one_low(anode_s);
  assign idx_s    = low_index(anode_s);

  // Frame assembly, timeout and error-event decisions for the current cycle.
  always_comb begin
    frame_s     = frame_r;
    mask_s      = mask_r;
    glyph_set_s = 1'b0;
    anode_set_s = 1'b0;
    complete_s  = 1'b0;
    if (tmo_r == TMO_MAX) begin
      tmo_s = tmo_r;
    end else begin
      tmo_s = tmo_r + TMO_W'(1);
    end

    if (accept_s) begin
      if (onehot_s) begin
        tmo_s = '0;
        if (glyph_s[4]) begin
          frame_s[{idx_s, 2'b00} +: 4] = glyph_s[3:0];
          mask_s = mask_r | (8'h01 << idx_s);
        end else begin
          glyph_set_s = 1'b1;
        end
      end else if (anode_s != 8'hFF) begin
        anode_set_s = 1'b1;
      end else begin
        anode_set_s = 1'b0;
      end
    end else begin
      complete_s = 1'b0;
    end

    if (mask_s == 8'hFF) begin
      complete_s = 1'b1;
      mask_s     = 8'h00;
    end else begin
      complete_s = 1'b0;
    end

    // Losing the scan discards whatever partial frame was collected.
    lost_rise_s = (tmo_s == TMO_MAX) && (tmo_r != TMO_MAX);
    if (lost_rise_s) begin
      mask_s = 8'h00;
    end else begin
      mask_s = mask_s;
    end
  end

  // Frame buffer, mask, timeout counter and registered outputs.
  always_ff @(posedge system_clock) begin
    if (cpu_rst) begin
      frame_r     <= 32'h0000_0000;
      mask_r      <= 8'h00;
      tmo_r       <= '0;
      value_r     <= 32'h0000_0000;
      valid_r     <= 1'b0;
      changed_r   <= 1'b0;
      glyph_err_r <= 1'b0;
      anode_err_r <= 1'b0;
      scan_lost_r <= 1'b0;
    end else begin
      frame_r     <= frame_s;
      mask_r      <= mask_s;
      tmo_r       <= tmo_s;
      scan_lost_r <= (tmo_s == TMO_MAX);
      valid_r     <= complete_s;
      if (complete_s) begin
        value_r   <= frame_s;
        changed_r <= (frame_s != value_r);
      end else begin
        value_r   <= value_r;
        changed_r <= 1'b0;
      end
      // An error event in the same cycle as err_clear keeps the flag set.
      if (glyph_set_s) begin
        glyph_err_r <= 1'b1;
      end else if (err_clear) begin
        glyph_err_r <= 1'b0;
      end else begin
        glyph_err_r <= glyph_err_r;
      end
      if (anode_set_s) begin
        anode_err_r <= 1'b1;
      end else if (err_clear) begin
        anode_err_r <= 1'b0;
      end else begin
        anode_err_r <= anode_err_r;
      end
    end
  end

  assign value_out     = value_r;
  assign value_valid   = valid_r;
  assign value_changed = changed_r;
  assign digit_mask    = mask_r;
  assign glyph_err     = glyph_err_r;
  assign anode_err     = anode_err_r;
  assign scan_lost     = scan_lost_r;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed testbench for seven_segment_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).

module tb_seven_segment_capture;

  logic        system_clock;
  logic        cpu_rst;
  logic [7:0]  anode_in;
  logic [6:0]  cathodes_in;
  logic        err_clear;
  logic [31:0] value_out;
  logic        value_valid;
  logic        value_changed;
  logic [7:0]  digit_mask;
  logic        glyph_err;
  logic        anode_err;
  logic        scan_lost;

  int checks;
  int errors;
  int vld_cnt;
  int chg_cnt;
  int last_vld_iter;
  logic [7:0] mask_pre;

  seven_segment_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .system_clock  (system_clock),
    .cpu_rst       (cpu_rst),
    .anode_in      (anode_in),
    .cathodes_in   (cathodes_in),
    .err_clear     (err_clear),
    .value_out     (value_out),
    .value_valid   (value_valid),
    .value_changed (value_changed),
    .digit_mask    (digit_mask),
    .glyph_err     (glyph_err),
    .anode_err     (anode_err),
    .scan_lost     (scan_lost)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] an_sel(input int k);
    return 8'hFF ^ (8'h01 << k);
  endfunction

  // Drive a pattern for n edges; err_clear is high for edge clr_at (0 = never).
  task automatic hold(input logic [7:0] an, input logic [6:0] cat, input int n, input int clr_at);
    anode_in    = an;
    cathodes_in = cat;
    for (int i = 1; i <= n; i++) begin
      err_clear = (i == clr_at) ? 1'b1 : 1'b0;
      @(posedge system_clock);
      #1;
      err_clear = 1'b0;
      if (value_valid === 1'b1) begin
        vld_cnt++;
        last_vld_iter = i;
      end
      if (value_changed === 1'b1) chg_cnt++;
    end
  endtask

  task automatic scan_frame(input logic [31:0] v, input bit glitch);
    logic [3:0] nib;
    vld_cnt = 0;
    chg_cnt = 0;
    last_vld_iter = 0;
    for (int k = 7; k >= 0; k--) begin
      nib = v[4*k +: 4];
      if (glitch) begin
        hold(an_sel(k), 7'b1111111, 2, 0);
        hold(an_sel(k), 7'b0000000, 2, 0);
      end
      if (k == 0) mask_pre = digit_mask;
      hold(an_sel(k), glyph(nib), 10, 0);
    end
  endtask

  task automatic test_reset;
    checks++; if (value_out !== 32'h0) begin errors++; $display("FAIL reset_value got %h exp %h", value_out, 32'h0); end
    checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", value_valid); end
    checks++; if (value_changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b exp 0", value_changed); end
    checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h exp 00", digit_mask); end
    checks++; if (glyph_err !== 1'b0) begin errors++; $display("FAIL reset_glyph_err got %b exp 0", glyph_err); end
    checks++; if (anode_err !== 1'b0) begin errors++; $display("FAIL reset_anode_err got %b exp 0", anode_err); end
    checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL reset_scan_lost got %b exp 0", scan_lost); end
  endtask

  task automatic test_clean_scan;
    scan_frame(32'h1234ABCD, 1'b0);
    checks++; if (mask_pre !== 8'hFE) begin errors++; $display("FAIL clean_mask_pre got %h exp FE", mask_pre); end
    checks++; if (value_out !== 32'h1234ABCD) begin errors++; $display("FAIL clean_value got %h exp 1234abcd", value_out); end
    checks++; if (vld_cnt != 1) begin errors++; $display("FAIL clean_valid_count got %0d exp 1", vld_cnt); end
    checks++; if (last_vld_iter != 4) begin errors++; $display("FAIL clean_latency got %0d exp 4", last_vld_iter); end
    checks++; if (chg_cnt != 1) begin errors++; $display("FAIL clean_changed got %0d exp 1", chg_cnt); end
    checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL clean_mask_end got %h exp 00", digit_mask); end
  endtask

  task automatic test_back_to_back;
    scan_frame(32'h1234ABCD, 1'b0);
    checks++; if (value_out !== 32'h1234ABCD) begin errors++; $display("FAIL repeat_value got %h exp 1234abcd", value_out); end
    checks++; if (vld_cnt != 1) begin errors++; $display("FAIL repeat_valid_count got %0d exp 1", vld_cnt); end
    checks++; if (chg_cnt != 0) begin errors++; $display("FAIL repeat_changed got %0d exp 0", chg_cnt); end
    checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL repeat_mask got %h exp 00", digit_mask); end
  endtask

  task automatic test_glitch;
    scan_frame(32'h1234ABCD, 1'b1);
    checks++; if (value_out !== 32'h1234ABCD) begin errors++; $display("FAIL glitch_value got %h exp 1234abcd", value_out); end
    checks++; if (vld_cnt != 1) begin errors++; $display("FAIL glitch_valid_count got %0d exp 1", vld_cnt); end
    checks++; if (chg_cnt != 0) begin errors++; $display("FAIL glitch_changed got %0d exp 0", chg_cnt); end
    checks++; if (glyph_err !== 1'b0) begin errors++; $display("FAIL glitch_glyph_err got %b exp 0", glyph_err); end
  endtask

  task automatic test_glyph_err;
    hold(an_sel(3), 7'b1111111, 10, 0);
    checks++; if (glyph_err !== 1'b1) begin errors++; $display("FAIL bad_glyph_err got %b exp 1", glyph_err); end
    checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL bad_glyph_mask got %h exp 00", digit_mask); end
    hold(8'hFF, 7'b1111111, 5, 2);
    checks++; if (glyph_err !== 1'b0) begin errors++; $display("FAIL glyph_clear got %b exp 0", glyph_err); end
    hold(an_sel(2), 7'b1111111, 10, 4);
    checks++; if (glyph_err !== 1'b1) begin errors++; $display("FAIL glyph_clear_collide got %b exp 1", glyph_err); end
  endtask

  task automatic test_anode_err;
    hold(8'hFF, 7'b1111111, 5, 1);
    checks++; if (glyph_err !== 1'b0) begin errors++; $display("FAIL anode_pre_glyph got %b exp 0", glyph_err); end
    hold(an_sel(5), glyph(4'h3), 10, 0);
    checks++; if (digit_mask !== 8'h20) begin errors++; $display("FAIL anode_mask_setup got %h exp 20", digit_mask); end
    hold(8'b11110011, glyph(4'h0), 10, 0);
    checks++; if (anode_err !== 1'b1) begin errors++; $display("FAIL anode_err_set got %b exp 1", anode_err); end
    checks++; if (digit_mask !== 8'h20) begin errors++; $display("FAIL anode_err_mask got %h exp 20", digit_mask); end
    hold(8'hFF, 7'b1111111, 10, 1);
    checks++; if (anode_err !== 1'b0) begin errors++; $display("FAIL blank_no_err got %b exp 0", anode_err); end
    checks++; if (digit_mask !== 8'h20) begin errors++; $display("FAIL blank_mask got %h exp 20", digit_mask); end
  endtask

  task automatic test_timeout;
    hold(an_sel(7), glyph(4'h1), 10, 0);
    hold(an_sel(6), glyph(4'h2), 10, 0);
    hold(an_sel(5), glyph(4'h3), 10, 0);
    hold(an_sel(4), glyph(4'h4), 10, 0);
    hold(an_sel(3), glyph(4'hA), 10, 0);
    checks++; if (digit_mask !== 8'hF8) begin errors++; $display("FAIL timeout_mask_setup got %h exp f8", digit_mask); end
    hold(8'hFF, 7'b1111111, 43, 0);
    checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", scan_lost); end
    hold(8'hFF, 7'b1111111, 1, 0);
    checks++; if (scan_lost !== 1'b1) begin errors++; $display("FAIL timeout_lost got %b exp 1", scan_lost); end
    checks++; if (digit_mask !== 8'h00) begin errors++; $display("FAIL timeout_mask got %h exp 00", digit_mask); end
    hold(an_sel(0), glyph(4'hD), 3, 0);
    checks++; if (scan_lost !== 1'b1) begin errors++; $display("FAIL lost_before_accept got %b exp 1", scan_lost); end
    hold(an_sel(0), glyph(4'hD), 1, 0);
    checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL lost_fall got %b exp 0", scan_lost); end
    checks++; if (digit_mask !== 8'h01) begin errors++; $display("FAIL lost_fall_mask got %h exp 01", digit_mask); end
  endtask

  task automatic test_reset_midframe;
    hold(an_sel(1), glyph(4'hC), 10, 0);
    hold(8'b11110011, glyph(4'h0), 10, 0);
    checks++; if (digit_mask !== 8'h03 || anode_err !== 1'b1) begin
      errors++; $display("FAIL midframe_setup got mask %h aerr %b exp 03 1", digit_mask, anode_err);
    end
    cpu_rst = 1'b1;
    @(posedge system_clock);
    #1;
    test_reset();
    cpu_rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    vld_cnt     = 0;
    chg_cnt     = 0;
    last_vld_iter = 0;
    mask_pre    = 8'h00;
    cpu_rst     = 1'b1;
    anode_in    = 8'hFF;
    cathodes_in = 7'b1111111;
    err_clear   = 1'b0;
    repeat (3) @(posedge system_clock);
    #1;
    cpu_rst = 1'b0;
    test_reset();
    test_clean_scan();
    test_back_to_back();
    test_glitch();
    test_glyph_err();
    test_anode_err();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
